// File: rtl/connect4_pkg.sv
// Shared types, default board geometry and colour helper for the Connect-Four game engine.
package connect4_pkg;

    localparam int DEF_ROWS    = 6;
    localparam int DEF_COLS    = 7;
    localparam int DEF_WIN_LEN = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        RED   = 2'b01,
        GREEN = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        SELECT    = 2'd0,
        SCAN      = 2'd1,
        CHECK     = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    function automatic cell_t player_colour(input logic player);
        if (player) begin
            return GREEN;
        end else begin
            return RED;
        end
    endfunction

endpackage

// File: rtl/connect4_win_check.sv
// Combinational four-in-line detector centred on the most recently placed piece.
module connect4_win_check
    import connect4_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int COLS    = DEF_COLS,
    parameter int WIN_LEN = DEF_WIN_LEN
) (
    input  logic [ROWS-1:0][COLS-1:0][1:0] panel,
    input  logic [2:0]                     row,
    input  logic [2:0]                     col,
    input  cell_t                          colour,
    output logic                           win
);
    localparam logic signed [3:0] ROWS_S  = 4'(ROWS);
    localparam logic signed [3:0] COLS_S  = 4'(COLS);
    localparam logic [3:0]        WIN_CNT = 4'(WIN_LEN);
    // Direction vectors: horizontal, vertical, rising diagonal, falling diagonal.
    localparam logic signed [3:0] DR [4] = '{4'sd0, 4'sd1, 4'sd1, 4'sd1};
    localparam logic signed [3:0] DC [4] = '{4'sd1, 4'sd0, 4'sd1, 4'sb1111};

    logic signed [3:0] row_s;
    logic signed [3:0] col_s;
    logic signed [3:0] step;
    logic [3:0]        cnt;
    logic              fwd;
    logic              bwd;

    assign row_s = {1'b0, row};
    assign col_s = {1'b0, col};

    // Off-board neighbours (including signed wrap past +7) never match.
    function automatic logic cell_match(input logic [ROWS-1:0][COLS-1:0][1:0] p,
                                        input logic [1:0] c_want,
                                        input logic signed [3:0] r,
                                        input logic signed [3:0] c);
        if (r < 4'sd0 || r >= ROWS_S || c < 4'sd0 || c >= COLS_S) begin
            return 1'b0;
        end else begin
            return p[r[2:0]][c[2:0]] == c_want;
        end
    endfunction

    // Count unbroken runs outward in both senses of each direction.
    always_comb begin
        win  = 1'b0;
        cnt  = 4'd0;
        fwd  = 1'b0;
        bwd  = 1'b0;
        step = 4'sd0;
        for (int d = 0; d < 4; d++) begin
            cnt = 4'd1;
            fwd = 1'b1;
            bwd = 1'b1;
            for (int k = 1; k < WIN_LEN; k++) begin
                step = 4'(k);
                fwd  = fwd & cell_match(panel, colour, row_s + step * DR[d], col_s + step * DC[d]);
                bwd  = bwd & cell_match(panel, colour, row_s - step * DR[d], col_s - step * DC[d]);
                cnt  = cnt + {3'b000, fwd} + {3'b000, bwd};
            end
            if (cnt >= WIN_CNT) begin
                win = 1'b1;
            end else begin
                win = win;
            end
        end
    end

endmodule

// File: rtl/connect4_game_ctrl.sv
// Connect-Four game-state engine: cursor, piece drop scan, win/draw detection and board registers.
module connect4_game_ctrl
    import connect4_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int COLS    = DEF_COLS,
    parameter int WIN_LEN = DEF_WIN_LEN
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           btn_left,
    input  logic                           btn_right,
    input  logic                           btn_drop,
    output logic [ROWS-1:0][COLS-1:0][1:0] panel,
    output logic [COLS-1:0]                play,
    output logic                           player,
    output logic                           game_over,
    output logic [1:0]                     winner
);
    // move_cnt holds this value just before the board's final piece is checked.
    localparam logic [5:0]      LAST_MOVE = 6'(ROWS * COLS - 1);
    localparam logic [2:0]      TOP_ROW   = 3'(ROWS - 1);
    localparam logic [COLS-1:0] LEFTMOST  = {1'b1, {(COLS-1){1'b0}}};

    state_t     state;
    logic [5:0] move_cnt;
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] play_idx;
    logic       win;
    cell_t      colour;

    assign colour = player_colour(player);

    // Encode the one-hot cursor into a column index.
    always_comb begin
        play_idx = 3'd0;
        for (int i = 0; i < COLS; i++) begin
            if (play[i]) begin
                play_idx = 3'(i);
            end else begin
                play_idx = play_idx;
            end
        end
    end

    connect4_win_check #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .WIN_LEN (WIN_LEN)
    ) u_win_check (
        .panel  (panel),
        .row    (row),
        .col    (col),
        .colour (colour),
        .win    (win)
    );

    // Game FSM; owns every board, cursor and status register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SELECT;
            panel     <= '0;
            play      <= LEFTMOST;
            player    <= 1'b0;
            game_over <= 1'b0;
            winner    <= EMPTY;
            move_cnt  <= 6'd0;
            row       <= 3'd0;
            col       <= 3'd0;
        end else begin
            case (state)
                SELECT: begin
                    if (btn_drop) begin
                        col   <= play_idx;
                        row   <= 3'd0;
                        state <= SCAN;
                    end else if (btn_left && !btn_right) begin
                        if (!play[COLS-1]) play <= play << 1;
                    end else if (btn_right && !btn_left) begin
                        if (!play[0]) play <= play >> 1;
                    end
                end
                SCAN: begin
                    if (panel[row][col] == EMPTY) begin
                        panel[row][col] <= colour;
                        state           <= CHECK;
                    end else if (row == TOP_ROW) begin
                        state <= SELECT;
                    end else begin
                        row <= row + 3'd1;
                    end
                end
                CHECK: begin
                    move_cnt <= move_cnt + 6'd1;
                    if (win) begin
                        winner    <= colour;
                        game_over <= 1'b1;
                        play      <= '0;
                        player    <= ~player;
                        state     <= GAME_OVER;
                    end else if (move_cnt == LAST_MOVE) begin
                        winner    <= EMPTY;
                        game_over <= 1'b1;
                        play      <= '0;
                        player    <= 1'b0;
                        state     <= GAME_OVER;
                    end else begin
                        player <= ~player;
                        state  <= SELECT;
                    end
                end
                GAME_OVER: begin
                    if (btn_drop) begin
                        panel     <= '0;
                        move_cnt  <= 6'd0;
                        play      <= LEFTMOST;
                        game_over <= 1'b0;
                        winner    <= EMPTY;
                        state     <= SELECT;
                    end
                end
                default: state <= SELECT;
            endcase
        end
    end

endmodule

// File: tb/tb_connect4_game_ctrl.sv
// Scoreboard bench for connect4_game_ctrl: directed moves push expectations, a monitor compares.
module tb_connect4_game_ctrl;

    typedef enum int {K_CELL, K_PANEL, K_PLAY, K_PLAYER, K_OVER, K_WINNER} kind_t;

    typedef struct {
        int          cyc;
        string       name;
        kind_t       kind;
        int          r;
        int          c;
        logic [83:0] val;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  btn_left;
    logic                  btn_right;
    logic                  btn_drop;
    logic [5:0][6:0][1:0]  panel;
    logic [6:0]            play;
    logic                  player;
    logic                  game_over;
    logic [1:0]            winner;

    exp_t                  sb_q[$];
    int                    cyc = 0;
    int                    checks = 0;
    int                    errors = 0;
    int                    seq[$];
    int                    px[3] = '{0, 1, 4};
    int                    py[3] = '{2, 3, 6};
    logic [5:0][6:0][1:0]  board;

    connect4_game_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_drop  (btn_drop),
        .panel     (panel),
        .play      (play),
        .player    (player),
        .game_over (game_over),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1);
    end

    // Monitor: pops every expectation due in the current cycle and compares on the falling edge.
    initial begin
        exp_t        e;
        logic [83:0] act;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                case (e.kind)
                    K_CELL:   act = {82'd0, panel[e.r][e.c]};
                    K_PANEL:  act = panel;
                    K_PLAY:   act = {77'd0, play};
                    K_PLAYER: act = {83'd0, player};
                    K_OVER:   act = {83'd0, game_over};
                    K_WINNER: act = {82'd0, winner};
                    default:  act = '0;
                endcase
                checks++;
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
                end else if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %0h, required %0h", e.name, act, e.val);
                end
            end
        end
    end

    task automatic push(input string name, input kind_t kind, input int r, input int c,
                        input logic [83:0] val);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.kind = kind;
        e.r    = r;
        e.c    = c;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic exp_cell(input string name, input int r, input int c, input logic [1:0] v);
        push(name, K_CELL, r, c, {82'd0, v});
    endtask

    task automatic exp_panel(input string name, input logic [83:0] v);
        push(name, K_PANEL, 0, 0, v);
    endtask

    task automatic exp_play(input string name, input logic [6:0] v);
        push(name, K_PLAY, 0, 0, {77'd0, v});
    endtask

    task automatic exp_bit(input string name, input kind_t kind, input logic v);
        push(name, kind, 0, 0, {83'd0, v});
    endtask

    task automatic exp_winner(input string name, input logic [1:0] v);
        push(name, K_WINNER, 0, 0, {82'd0, v});
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic l, input logic r, input logic d);
        btn_left  = l;
        btn_right = r;
        btn_drop  = d;
        tick(1);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_drop  = 1'b0;
    endtask

    task automatic goto_col(input int col);
        for (int i = 0; i < 7; i++) press(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6 - col; i++) press(1'b0, 1'b1, 1'b0);
    endtask

    task automatic drop_in(input int col);
        goto_col(col);
        press(1'b0, 1'b0, 1'b1);
        tick(8);
    endtask

    initial begin
        rst       = 1'b1;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_drop  = 1'b0;
        tick(2);
        rst = 1'b0;
        exp_panel("reset_panel", 84'd0);
        exp_play("reset_play", 7'b1000000);
        exp_bit("reset_player", K_PLAYER, 1'b0);
        exp_bit("reset_game_over", K_OVER, 1'b0);
        exp_winner("reset_winner", 2'b00);

        // Cursor saturation and simultaneous buttons.
        for (int i = 0; i < 8; i++) press(1'b0, 1'b1, 1'b0);
        exp_play("cursor_right_sat", 7'b0000001);
        press(1'b1, 1'b1, 1'b0);
        exp_play("cursor_both", 7'b0000001);
        press(1'b1, 1'b0, 1'b0);
        exp_play("cursor_left", 7'b0000010);

        // Drop latency and stacking in column 6.
        goto_col(6);
        press(1'b0, 1'b0, 1'b1);
        exp_cell("drop0_pre", 0, 6, 2'b00);
        tick(1);
        exp_cell("drop0_land", 0, 6, 2'b01);
        exp_bit("drop0_player_hold", K_PLAYER, 1'b0);
        tick(2);
        exp_bit("drop0_player_next", K_PLAYER, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        tick(1);
        exp_cell("drop1_scan", 1, 6, 2'b00);
        tick(1);
        exp_cell("drop1_land", 1, 6, 2'b10);
        tick(3);
        exp_bit("drop1_player", K_PLAYER, 1'b0);

        // Fill column 3, then attempt a seventh drop.
        goto_col(3);
        for (int i = 0; i < 6; i++) begin
            press(1'b0, 1'b0, 1'b1);
            tick(8);
        end
        exp_cell("col3_top", 5, 3, 2'b10);
        exp_bit("col3_player", K_PLAYER, 1'b0);
        board       = '0;
        board[0][6] = 2'b01;
        board[1][6] = 2'b10;
        for (int r = 0; r < 6; r++) board[r][3] = (r % 2 == 0) ? 2'b01 : 2'b10;
        press(1'b0, 1'b0, 1'b1);
        tick(2);
        press(1'b1, 1'b0, 1'b0);
        exp_play("scan_ignores_left", 7'b0001000);
        tick(3);
        exp_panel("full_col_panel", board);
        exp_bit("full_col_player", K_PLAYER, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        exp_play("full_col_select", 7'b0010000);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_panel("rst_clear", 84'd0);

        // Red horizontal win along row 0.
        drop_in(6); drop_in(6); drop_in(5); drop_in(5); drop_in(4); drop_in(4);
        exp_bit("red_not_yet", K_OVER, 1'b0);
        drop_in(3);
        exp_bit("red_game_over", K_OVER, 1'b1);
        exp_winner("red_winner", 2'b01);
        exp_play("red_play_off", 7'b0000000);
        exp_cell("red_last_cell", 0, 3, 2'b01);
        press(1'b1, 1'b0, 1'b0);
        exp_play("over_left_ignored", 7'b0000000);
        press(1'b0, 1'b0, 1'b1);
        exp_panel("red_restart_panel", 84'd0);
        exp_bit("red_restart_over", K_OVER, 1'b0);
        exp_winner("red_restart_winner", 2'b00);
        exp_play("red_restart_play", 7'b1000000);
        exp_bit("red_loser_starts", K_PLAYER, 1'b1);

        // Green rising-diagonal win; green moves first.
        drop_in(0); drop_in(1); drop_in(1); drop_in(2); drop_in(3);
        drop_in(2); drop_in(2); drop_in(3); drop_in(6); drop_in(3);
        exp_bit("green_not_yet", K_OVER, 1'b0);
        drop_in(3);
        exp_bit("green_game_over", K_OVER, 1'b1);
        exp_winner("green_winner", 2'b10);
        exp_cell("green_last_cell", 3, 3, 2'b10);
        press(1'b0, 1'b0, 1'b1);
        exp_panel("green_restart_panel", 84'd0);
        exp_bit("green_restart_over", K_OVER, 1'b0);
        exp_bit("green_loser_starts", K_PLAYER, 1'b0);

        // Draw: column pairs dropped X,Y,Y,X then column 5 alone.
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 3; j++) begin
                seq.push_back(px[p]);
                seq.push_back(py[p]);
                seq.push_back(py[p]);
                seq.push_back(px[p]);
            end
        end
        for (int j = 0; j < 6; j++) seq.push_back(5);
        for (int i = 0; i < 41; i++) drop_in(seq[i]);
        exp_bit("draw_not_yet", K_OVER, 1'b0);
        drop_in(seq[41]);
        exp_bit("draw_game_over", K_OVER, 1'b1);
        exp_winner("draw_winner", 2'b00);
        exp_bit("draw_player", K_PLAYER, 1'b0);
        exp_play("draw_play_off", 7'b0000000);
        exp_cell("draw_top_cell", 5, 5, 2'b10);
        exp_cell("draw_corner_cell", 0, 0, 2'b01);
        press(1'b0, 1'b0, 1'b1);
        exp_panel("draw_restart_panel", 84'd0);

        // Reset while a drop is still scanning column 0.
        drop_in(0); drop_in(0); drop_in(0);
        exp_bit("pre_rst_player", K_PLAYER, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_panel("rst_scan_panel", 84'd0);
        exp_play("rst_scan_play", 7'b1000000);
        exp_bit("rst_scan_player", K_PLAYER, 1'b0);
        exp_bit("rst_scan_over", K_OVER, 1'b0);
        exp_winner("rst_scan_winner", 2'b00);
        tick(4);
        exp_panel("rst_scan_discard", 84'd0);

        tick(2);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
